// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and sample pair type for the I2S transmitter
package audio_pkg;

  localparam int AUDIO_FRAME_BITS   = 64;
  localparam int AUDIO_SLOT_BITS    = 32;
  localparam int AUDIO_BIT_CNT_W    = $clog2(AUDIO_FRAME_BITS);
  // Widest sample that still leaves the one-BCLK I2S delay inside a slot.
  localparam int AUDIO_SAMPLE_W_MAX = AUDIO_SLOT_BITS - 1;

  // Samples are held MSB-aligned so one type serves every SAMPLE_W.
  typedef struct packed {
    logic [AUDIO_SAMPLE_W_MAX-1:0] left;
    logic [AUDIO_SAMPLE_W_MAX-1:0] right;
  } audio_pair_t;

endpackage

// File: rtl/audio_clk_div.sv
// rtl/audio_clk_div.sv - BCLK divider, falling-edge strobe and frame bit counter
module audio_clk_div
  import audio_pkg::*;
#(
  parameter int MCLK_DIV = 3
) (
  input  logic                       clk,
  input  logic                       clr,
  output logic                       bclk,
  output logic                       fe,
  output logic [AUDIO_BIT_CNT_W-1:0] bit_cnt
);

  localparam int            DW       = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(MCLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == DIV_LAST);
  // A wrap while BCLK is high is the BCLK falling edge.
  assign fe   = wrap && bclk;

  // Divide refclk down to BCLK and count bit positions on each falling edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '1;
    end else begin
      if (wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fe) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - stereo I2S transmitter top; AUDIO_TX_HOLD_EN repeats the last pair on underrun
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int MCLK_DIV = 3,
  parameter int SAMPLE_W = 16
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                locked,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                aud_bclk,
  output logic                aud_lrck,
  output logic                aud_dacdat,
  output logic                underrun
);

  localparam int         SW     = AUDIO_SAMPLE_W_MAX;
  localparam logic [4:0] LAST_B = 5'(SAMPLE_W);

  logic                       clr;
  logic                       fe;
  logic [AUDIO_BIT_CNT_W-1:0] bit_cnt;
  logic [AUDIO_BIT_CNT_W-1:0] bit_nxt;
  logic [4:0]                 b_nxt;
  logic                       frame_load;
  logic                       shift_now;
  logic                       xfer;

  audio_pair_t                pend_pair;
  logic                       pend_full;
  logic [SW-1:0]              sh_left;
  logic [SW-1:0]              sh_right;
`ifdef AUDIO_TX_HOLD_EN
  audio_pair_t                last_pair;
`endif

  function automatic logic [SW-1:0] msb_align(input logic [SAMPLE_W-1:0] s);
    return SW'(s) << (SW - SAMPLE_W);
  endfunction

  // Lock loss is treated exactly like reset.
  assign clr        = rst || !locked;
  assign bit_nxt    = bit_cnt + 1'b1;
  assign b_nxt      = bit_nxt[4:0];
  assign frame_load = fe && (bit_cnt == '1) && !clr;
  // Slot position 0 is the one-BCLK delay; positions past the sample width pad with zeros.
  assign shift_now  = (b_nxt != 5'd0) && (b_nxt <= LAST_B);
  assign s_ready    = !pend_full && !clr;
  assign xfer       = s_valid && s_ready;
  assign underrun   = frame_load && !pend_full;

  audio_clk_div #(
    .MCLK_DIV(MCLK_DIV)
  ) u_clk_div (
    .clk    (refclk),
    .clr    (clr),
    .bclk   (aud_bclk),
    .fe     (fe),
    .bit_cnt(bit_cnt)
  );

  // Single-entry buffer: drained by the frame load, refilled by the handshake.
  always_ff @(posedge refclk) begin
    if (clr) begin
      pend_full <= 1'b0;
      pend_pair <= '0;
`ifdef AUDIO_TX_HOLD_EN
      last_pair <= '0;
`endif
    end else begin
      if (frame_load && pend_full) begin
        pend_full <= 1'b0;
`ifdef AUDIO_TX_HOLD_EN
        last_pair <= pend_pair;
`endif
      end
      // Only possible while empty, so a write never collides with the drain above.
      if (xfer) begin
        pend_pair.left  <= msb_align(s_left);
        pend_pair.right <= msb_align(s_right);
        pend_full       <= 1'b1;
      end
    end
  end

  // Shift registers and registered pin outputs, all advanced on the BCLK falling edge.
  always_ff @(posedge refclk) begin
    if (clr) begin
      sh_left    <= '0;
      sh_right   <= '0;
      aud_lrck   <= 1'b1;
      aud_dacdat <= 1'b0;
    end else if (fe) begin
      if (frame_load) begin
        if (pend_full) begin
          sh_left  <= pend_pair.left;
          sh_right <= pend_pair.right;
        end else begin
`ifdef AUDIO_TX_HOLD_EN
          sh_left  <= last_pair.left;
          sh_right <= last_pair.right;
`else
          sh_left  <= '0;
          sh_right <= '0;
`endif
        end
      end else if (shift_now) begin
        if (bit_nxt[5]) begin
          sh_right <= sh_right << 1;
        end else begin
          sh_left  <= sh_left << 1;
        end
      end
      aud_lrck   <= bit_nxt[5];
      aud_dacdat <= shift_now ? (bit_nxt[5] ? sh_right[SW-1] : sh_left[SW-1]) : 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb/tb_audio_i2s_tx.sv - scoreboard bench for audio_i2s_tx
module tb_audio_i2s_tx;

  localparam int MCLK_DIV   = 3;
  localparam int SAMPLE_W   = 16;
  localparam int FRAME_CYC  = 64 * 2 * MCLK_DIV;
  localparam int FIRST_LOAD = 2 * MCLK_DIV;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        locked = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_left = 16'h0;
  logic [15:0] s_right = 16'h0;
  logic        s_ready;
  logic        aud_bclk;
  logic        aud_lrck;
  logic        aud_dacdat;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  pair_t sb_q[$];
  pair_t m_pend;
  pair_t m_last;
  bit    m_full = 1'b0;
  int    m_cyc = 0;
  bit    m_rst_state = 1'b1;
  bit    hs_flag = 1'b0;
  bit    bp_mode = 1'b0;
  int    bp_hs_cnt = 0;
  int    last_hs_cyc = 0;

  int          tcyc = 0;
  int          last_bclk_rise = -1;
  int          last_lrck_rise = -1;
  logic        prev_bclk = 1'b0;
  logic        prev_lrck = 1'b1;
  logic        mon_prev_lrck = 1'b1;
  bit          in_frame = 1'b0;
  int          fidx = 0;
  logic [63:0] fbits = '0;

  audio_i2s_tx #(
    .MCLK_DIV(MCLK_DIV),
    .SAMPLE_W(SAMPLE_W)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_left    (s_left),
    .s_right   (s_right),
    .aud_bclk  (aud_bclk),
    .aud_lrck  (aud_lrck),
    .aud_dacdat(aud_dacdat),
    .underrun  (underrun)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model, monitor and scoreboard; the negedge predicts the coming posedge.
  always @(negedge refclk) begin
    bit    act;
    bit    rdy;
    bit    load;
    pair_t p;
    pair_t zero_pair;
    zero_pair = '0;
    tcyc++;
    act  = !rst && locked;
    rdy  = act && !m_full;
    load = act && (m_cyc + 1 >= FIRST_LOAD) && (((m_cyc + 1 - FIRST_LOAD) % FRAME_CYC) == 0);

    check("s_ready", 64'(s_ready), 64'(rdy));
    check("underrun", 64'(underrun), 64'(load && !m_full));

    if (m_rst_state) begin
      check("idle_pins", 64'({aud_bclk, aud_lrck, aud_dacdat}), 64'(3'b010));
      last_bclk_rise = -1;
      last_lrck_rise = -1;
      in_frame       = 1'b0;
      mon_prev_lrck  = 1'b1;
    end else begin
      if (aud_bclk && !prev_bclk) begin
        if (last_bclk_rise >= 0)
          check("bclk_period", 64'(tcyc - last_bclk_rise), 64'(2 * MCLK_DIV));
        last_bclk_rise = tcyc;
        if (!aud_lrck && mon_prev_lrck) begin
          in_frame = 1'b1;
          fidx     = 0;
        end
        if (in_frame) begin
          fbits[63 - fidx] = aud_dacdat;
          fidx++;
          if (fidx == 64) begin
            in_frame = 1'b0;
            check("sb_avail", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
              p = sb_q.pop_front();
              check("frame", fbits, {1'b0, p.l, 15'b0, 1'b0, p.r, 15'b0});
            end
          end
        end
        mon_prev_lrck = aud_lrck;
      end
      if (aud_lrck !== prev_lrck) begin
        check("lrck_at_fe", 64'({prev_bclk, aud_bclk}), 64'(2'b10));
        if (aud_lrck) begin
          if (last_lrck_rise >= 0)
            check("lrck_period", 64'(tcyc - last_lrck_rise), 64'(FRAME_CYC));
          last_lrck_rise = tcyc;
        end else if (last_lrck_rise >= 0) begin
          check("lrck_high", 64'(tcyc - last_lrck_rise), 64'(FRAME_CYC / 2));
        end
      end
    end
    prev_bclk = aud_bclk;
    prev_lrck = aud_lrck;

    hs_flag = 1'b0;
    if (!act) begin
      m_full      = 1'b0;
      m_pend      = '0;
      m_last      = '0;
      m_cyc       = 0;
      m_rst_state = 1'b1;
      sb_q.delete();
    end else begin
      if (load) begin
        if (m_full) begin
          sb_q.push_back(m_pend);
          m_last = m_pend;
          m_full = 1'b0;
        end else begin
`ifdef AUDIO_TX_HOLD_EN
          sb_q.push_back(m_last);
`else
          sb_q.push_back(zero_pair);
`endif
        end
      end
      if (s_valid && rdy) begin
        m_pend  = {s_left, s_right};
        m_full  = 1'b1;
        hs_flag = 1'b1;
        if (bp_mode) begin
          bp_hs_cnt++;
          if (bp_hs_cnt >= 3)
            check("bp_interval", 64'(m_cyc - last_hs_cyc), 64'(FRAME_CYC));
          last_hs_cyc = m_cyc;
        end
      end
      m_cyc++;
      m_rst_state = 1'b0;
    end
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    bit got;
    got     = 1'b0;
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME_CYC && !got; i++) begin
      tick();
      got = hs_flag;
    end
    s_valid = 1'b0;
    check("send_hs", 64'(got), 64'd1);
  endtask

  task automatic wait_phase(input int ph);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME_CYC && !hit; i++) begin
      tick();
      hit = (m_cyc >= FIRST_LOAD) && (((m_cyc - FIRST_LOAD) % FRAME_CYC) == ph);
    end
    check("phase_wait", 64'(hit), 64'd1);
  endtask

  initial begin
    int n;
    repeat (10) tick();
    rst     = 1'b0;
    locked  = 1'b0;
    s_valid = 1'b1;
    s_left  = 16'hDEAD;
    s_right = 16'hBEEF;
    repeat (20) tick();
    s_valid = 1'b0;
    locked  = 1'b1;

    send(16'hA5C3, 16'h8001);
    repeat (2 * FRAME_CYC + 50) tick();

    bp_mode   = 1'b1;
    bp_hs_cnt = 0;
    n         = 0;
    s_left    = 16'h0100;
    s_right   = 16'hFF00;
    s_valid   = 1'b1;
    for (int i = 0; i < 6 * FRAME_CYC && n < 5; i++) begin
      tick();
      if (hs_flag) begin
        n++;
        s_left  = s_left + 16'd1;
        s_right = s_right - 16'd1;
      end
    end
    s_valid = 1'b0;
    bp_mode = 1'b0;
    check("bp_count", 64'(n), 64'd5);

    send(16'h1234, 16'h4321);
    repeat (4 * FRAME_CYC) tick();

    wait_phase(0);
    send(16'h5A5A, 16'h0F0F);
    wait_phase(20 * 2 * MCLK_DIV + 1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3 * FRAME_CYC) tick();

    repeat (20) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
